ifu_imem_resp: RTL and testbench
================================

Name: ifu_imem_resp

Overview:
- Instruction-memory responder at the far end of the fetch path.
- Accepts a fetch request carrying the PC from the program-counter/fetch side over a valid/ready handshake.
- Returns the 32-bit instruction word after a configurable fixed latency over a second valid/ready handshake.
- Flags misaligned or out-of-range PCs as errors; provides a side load port for test/boot image writes.

Parameters:
- BITWIDTH, 32, width of the request address (PC).
- BASE_ADDR, 32'h80000000, byte address of memory word 0; matches the PC reset value.
- DEPTH_LOG2, 12, log2 of memory depth in 32-bit words (default 4096 words = 16 KiB).
- LATENCY, 1, cycles from request acceptance edge to resp_valid high; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  fetch request valid.
- req_ready  output  1  responder can accept a request.
- req_addr  input  BITWIDTH  fetch byte address (PC).
- resp_valid  output  1  response valid.
- resp_ready  input  1  consumer accepts the response.
- resp_inst  output  32  instruction word.
- resp_err  output  1  request was misaligned or out of range.
- ld_en  input  1  load-port write enable.
- ld_addr  input  DEPTH_LOG2  load-port word index.
- ld_data  input  32  load-port write data.

Behaviour:
- Reset: state IDLE; req_ready=1 combinationally from IDLE; resp_valid=0, resp_inst=0, resp_err=0; latency counter=0. Memory contents are not cleared.
- Reset mid-operation: any pending request is dropped silently, with no response issued.
- States: IDLE, WAIT, RESP. req_ready=1 only in IDLE; resp_valid=1 only in RESP.
- IDLE, req_valid=1 (handshake at edge E):
  - Latch word index (req_addr-BASE_ADDR)>>2 and the error flag.
  - LATENCY==1: go to RESP at E; memory read at E; resp_valid visible the cycle after E.
  - Otherwise: go to WAIT, counter=LATENCY-2.
- WAIT:
  - Counter!=0: decrement each edge.
  - Counter==0: next edge reads memory and goes to RESP.
  - Net effect: resp_valid rises exactly LATENCY cycles after E.
- RESP:
  - resp_inst and resp_err are held stable while resp_valid=1 and resp_ready=0.
  - On edge with resp_ready=1: go to IDLE; resp_valid=0; resp_inst/resp_err keep their last values.
  - No request is accepted in the same cycle as the response handshake.
  - Max throughput: one fetch per LATENCY+1 cycles.
- Error rule, evaluated on req_addr at acceptance:
  - err = (req_addr[1:0]!=0) OR (req_addr<BASE_ADDR) OR (req_addr-BASE_ADDR >= 4<<DEPTH_LOG2).
  - Subtraction is BITWIDTH-bit unsigned; the explicit < BASE_ADDR check covers wrap-around.
  - On error: resp_inst=32'h0, resp_err=1, no memory read. Otherwise resp_err=0.
- Load port:
  - ld_en writes mem[ld_addr]=ld_data at the edge, in any state, including during reset.
  - Same-edge write and read of the same index: the read returns the OLD word (read-before-write).
  - A write landing between acceptance and the read edge is visible in the response.
- req_addr is ignored outside the IDLE acceptance edge.
- resp_ready is ignored outside RESP.

Test Plan:
- LATENCY=1; load mem[0]=32'h00000413, mem[1]=32'h00100093; request 0x80000000 at edge E, resp_ready=1 -> resp_valid at E+1, resp_inst=32'h00000413, resp_err=0; request 0x80000004 next -> 32'h00100093.
- LATENCY=3; request 0x80000004 at E -> req_ready=0 for E+1..E+3; resp_valid exactly at E+3 with 32'h00100093.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_inst, resp_err stable all 5 cycles; resp_ready=1 -> IDLE next cycle, req_ready=1.
- Errors (DEPTH_LOG2=12):
  - 0x80000002 -> resp_err=1, inst=0.
  - 0x7FFFFFFC -> resp_err=1, inst=0.
  - 0x80004000 -> resp_err=1, inst=0.
  - 0x80003FFC -> resp_err=0, returns mem[4095].
- Reset mid-operation: LATENCY=3; assert rst one cycle in WAIT -> next cycle IDLE, resp_valid=0, resp_inst=0, no response issued; mem contents preserved on a re-fetch.
- Load collision: LATENCY=1; ld_en to index 0 with 32'hDEADBEEF on the acceptance edge of 0x80000000 -> response returns the old word; a repeat fetch returns 32'hDEADBEEF.

Source files
------------

// File: rtl/ifu_imem_resp.sv
// Instruction-memory responder: accepts a PC fetch request and returns the
// instruction word (or an error flag) after a fixed LATENCY, with a side load port.
module ifu_imem_resp #(
  parameter int                  BITWIDTH   = 32,
  parameter logic [BITWIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                  DEPTH_LOG2 = 12,
  parameter int                  LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [BITWIDTH-1:0]   req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_inst,
  output logic                  resp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [BITWIDTH:0] MEM_BYTES = (BITWIDTH + 1)'(1) << (DEPTH_LOG2 + 2);
  localparam logic [3:0]        CNT_INIT  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  err_q;
  logic [BITWIDTH-1:0]   req_off;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_err;
  logic                  accept;
  logic                  rd_fire;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_err;
  logic [31:0]           mem [DEPTH];

  // The explicit below-base check catches PCs whose offset wraps into range.
  assign req_off = req_addr - BASE_ADDR;
  assign req_idx = req_off[DEPTH_LOG2+1:2];
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                   ({1'b0, req_off} >= MEM_BYTES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = req_valid ? ((LATENCY == 1) ? RESP : WAIT) : IDLE;
      WAIT: state_nxt = (cnt == 4'd0) ? RESP : WAIT;
      RESP: state_nxt = resp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY==1 the read happens on the acceptance edge itself, so the
  // read index/error bypass the latches in that case.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    rd_fire    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        rd_fire   = req_valid && (LATENCY == 1);
      end
      WAIT: rd_fire = (cnt == 4'd0);
      RESP: resp_valid = 1'b1;
      default: rd_fire = 1'b0;
    endcase
    accept = req_ready && req_valid;
    rd_idx = accept ? req_idx : idx_q;
    rd_err = accept ? req_err : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      resp_inst <= 32'h0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        idx_q <= req_idx;
        err_q <= req_err;
        cnt   <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (rd_fire) begin
        resp_err  <= rd_err;
        resp_inst <= rd_err ? 32'h0 : mem[rd_idx];
      end
    end
  end

  // Load port ignores reset; a same-edge read sees the previous word.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_ifu_imem_resp.sv
// Bench for ifu_imem_resp: LATENCY=1 and LATENCY=3 instances share stimulus and
// are checked every cycle against a cycle-count reference model.
module tb_ifu_imem_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        resp_ready = 1'b0;
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = 12'h0;
  logic [31:0] ld_data = 32'h0;

  logic        req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_inst1;
  logic        req_ready3, resp_valid3, resp_err3;
  logic [31:0] resp_inst3;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ifu_imem_resp #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_addr(req_addr), .resp_valid(resp_valid1), .resp_ready(resp_ready),
    .resp_inst(resp_inst1), .resp_err(resp_err1), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data)
  );

  ifu_imem_resp #(.LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready3),
    .req_addr(req_addr), .resp_valid(resp_valid3), .resp_ready(resp_ready),
    .resp_inst(resp_inst3), .resp_err(resp_err3), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per instance, a busy/remaining-edges view of a fetch.
  logic [31:0] m_mem [4096];
  bit          m_busy  [2] = '{1'b0, 1'b0};
  int          m_rem   [2] = '{0, 0};
  bit          m_valid [2] = '{1'b0, 1'b0};
  logic [31:0] m_inst  [2] = '{32'h0, 32'h0};
  bit          m_err   [2] = '{1'b0, 1'b0};
  int          m_idx   [2] = '{0, 0};
  bit          m_perr  [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int          lat = (k == 0) ? 1 : 3;
      automatic logic [63:0] a64;
      automatic bit          e;
      automatic int          ix;
      automatic bit          do_rd;
      automatic int          rd_ix;
      automatic bit          rd_e;
      do_rd = 1'b0;
      rd_ix = 0;
      rd_e  = 1'b0;
      a64   = {32'h0, req_addr};
      e     = ((a64 % 4) != 0) || (a64 < 64'h8000_0000) ||
              ((a64 - 64'h8000_0000) >= 64'd16384);
      ix    = e ? 0 : int'((a64 - 64'h8000_0000) / 4);
      if (rst) begin
        m_busy[k]  <= 1'b0;
        m_valid[k] <= 1'b0;
        m_inst[k]  <= 32'h0;
        m_err[k]   <= 1'b0;
      end else if (m_busy[k]) begin
        if (m_rem[k] == 1) begin
          do_rd = 1'b1; rd_ix = m_idx[k]; rd_e = m_perr[k];
        end else begin
          m_rem[k] <= m_rem[k] - 1;
        end
      end else if (m_valid[k]) begin
        if (resp_ready) m_valid[k] <= 1'b0;
      end else if (req_valid) begin
        m_idx[k]  <= ix;
        m_perr[k] <= e;
        if (lat == 1) begin
          do_rd = 1'b1; rd_ix = ix; rd_e = e;
        end else begin
          m_busy[k] <= 1'b1;
          m_rem[k]  <= lat - 1;
        end
      end
      if (do_rd) begin
        m_busy[k]  <= 1'b0;
        m_valid[k] <= 1'b1;
        m_err[k]   <= rd_e;
        m_inst[k]  <= rd_e ? 32'h0 : m_mem[rd_ix];
      end
    end
    if (ld_en) m_mem[ld_addr] <= ld_data;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready1", {31'h0, req_ready1}, {31'h0, !m_busy[0] && !m_valid[0]});
      chk("resp_valid1", {31'h0, resp_valid1}, {31'h0, m_valid[0]});
      chk("resp_inst1", resp_inst1, m_inst[0]);
      chk("resp_err1", {31'h0, resp_err1}, {31'h0, m_err[0]});
      chk("req_ready3", {31'h0, req_ready3}, {31'h0, !m_busy[1] && !m_valid[1]});
      chk("resp_valid3", {31'h0, resp_valid3}, {31'h0, m_valid[1]});
      chk("resp_inst3", resp_inst3, m_inst[1]);
      chk("resp_err3", {31'h0, resp_err3}, {31'h0, m_err[1]});
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(req_ready1 && req_ready3) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'h0, req_ready1 && req_ready3}, 32'h1);
  endtask

  // One-cycle request; resp_ready low until iteration bp; optional same-edge load.
  task automatic fetch(input logic [31:0] addr, input int bp, input bit ld0,
                       output logic [31:0] i1, output logic e1, output int l1,
                       output logic [31:0] i3, output logic e3, output int l3);
    bit done;
    done = 1'b0;
    i1 = 32'h0; e1 = 1'b0; l1 = -1;
    i3 = 32'h0; e3 = 1'b0; l3 = -1;
    wait_idle();
    req_valid  = 1'b1;
    req_addr   = addr;
    resp_ready = (bp == 0);
    if (ld0) begin
      ld_en = 1'b1; ld_addr = 12'd0; ld_data = 32'hDEADBEEF;
    end
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      ld_en     = 1'b0;
      if (resp_valid1) begin
        if (l1 < 0) begin
          l1 = i; i1 = resp_inst1; e1 = resp_err1;
        end else begin
          chk("hold_inst1", resp_inst1, i1);
          chk("hold_err1", {31'h0, resp_err1}, {31'h0, e1});
        end
      end
      if (resp_valid3) begin
        if (l3 < 0) begin
          l3 = i; i3 = resp_inst3; e3 = resp_err3;
        end else begin
          chk("hold_inst3", resp_inst3, i3);
          chk("hold_err3", {31'h0, resp_err3}, {31'h0, e3});
        end
      end
      if (i <= 3) chk("busy_ready3", {31'h0, req_ready3}, 32'h0);
      resp_ready = (i >= bp);
      done = (l1 > 0) && (l3 > 0) && req_ready1 && req_ready3;
    end
    chk("fetch_timeout", {31'h0, done}, 32'h1);
  endtask

  task automatic fetch_expect(input string name, input logic [31:0] addr, input int bp,
                              input bit ld0, input logic [31:0] exp1, input logic [31:0] exp3,
                              input logic experr);
    logic [31:0] i1, i3;
    logic        e1, e3;
    int          l1, l3;
    fetch(addr, bp, ld0, i1, e1, l1, i3, e3, l3);
    chk({name, "_inst1"}, i1, exp1);
    chk({name, "_err1"}, {31'h0, e1}, {31'h0, experr});
    chk({name, "_lat1"}, l1, 32'd1);
    chk({name, "_inst3"}, i3, exp3);
    chk({name, "_err3"}, {31'h0, e3}, {31'h0, experr});
    chk({name, "_lat3"}, l3, 32'd3);
  endtask

  initial begin
    // Preload the whole memory while reset is held; the load port works in reset.
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 12'(i);
      ld_data = (i == 0) ? 32'h0000_0413 : (i == 1) ? 32'h0010_0093 :
                (i == 4095) ? 32'hCAFE_F00D : $urandom;
    end
    @(negedge clk);
    ld_en  = 1'b0;
    chk_en = 1'b1;
    chk("rst_req_ready1", {31'h0, req_ready1}, 32'h1);
    chk("rst_resp_valid1", {31'h0, resp_valid1}, 32'h0);
    chk("rst_resp_inst1", resp_inst1, 32'h0);
    chk("rst_resp_valid3", {31'h0, resp_valid3}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    fetch_expect("w0", BASE, 0, 1'b0, 32'h0000_0413, 32'h0000_0413, 1'b0);
    fetch_expect("w1", BASE + 32'd4, 0, 1'b0, 32'h0010_0093, 32'h0010_0093, 1'b0);
    fetch_expect("bp", BASE + 32'd4, 9, 1'b0, 32'h0010_0093, 32'h0010_0093, 1'b0);
    fetch_expect("mis", 32'h8000_0002, 0, 1'b0, 32'h0, 32'h0, 1'b1);
    fetch_expect("below", 32'h7FFF_FFFC, 0, 1'b0, 32'h0, 32'h0, 1'b1);
    fetch_expect("above", 32'h8000_4000, 0, 1'b0, 32'h0, 32'h0, 1'b1);
    fetch_expect("last", 32'h8000_3FFC, 0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);

    // Reset while the LATENCY=3 instance is waiting drops the request.
    wait_idle();
    req_valid = 1'b1; req_addr = BASE; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_busy3", {31'h0, req_ready3}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_ready3", {31'h0, req_ready3}, 32'h1);
    chk("mid_valid3", {31'h0, resp_valid3}, 32'h0);
    chk("mid_inst3", resp_inst3, 32'h0);
    chk("mid_valid1", {31'h0, resp_valid1}, 32'h0);
    repeat (6) begin
      @(negedge clk);
      chk("mid_noresp3", {31'h0, resp_valid3}, 32'h0);
    end
    fetch_expect("refetch", BASE + 32'd4, 0, 1'b0, 32'h0010_0093, 32'h0010_0093, 1'b0);

    // Same-edge load: LATENCY=1 reads the old word, LATENCY=3 reads later and sees the new one.
    fetch_expect("coll", BASE, 0, 1'b1, 32'h0000_0413, 32'hDEAD_BEEF, 1'b0);
    fetch_expect("after", BASE, 0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      automatic int r = $urandom_range(0, 7);
      @(negedge clk);
      rst        = ($urandom_range(0, 199) == 0);
      req_valid  = ($urandom_range(0, 2) == 0);
      resp_ready = $urandom_range(0, 1) == 1;
      case (r)
        0, 1:    req_addr = BASE + 32'($urandom_range(0, 15)) * 32'd4;
        2, 3:    req_addr = BASE + 32'($urandom_range(0, 4095)) * 32'd4;
        4:       req_addr = BASE + 32'($urandom_range(0, 16383));
        5:       req_addr = BASE - 32'd4 * 32'($urandom_range(1, 4));
        6:       req_addr = BASE + 32'd16384 + 32'd4 * 32'($urandom_range(0, 3));
        default: req_addr = $urandom;
      endcase
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = 12'($urandom_range(0, 15));
      ld_data = $urandom;
    end
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; ld_en = 1'b0; resp_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
